frq_decoder: RTL and testbench



---
 rtl/frq_decoder.sv | 172 +++++++++++++++++
 tb/tb_frq_decoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/frq_decoder.sv
// rtl/frq_decoder.sv - recovers a 3-bit divider code from the period of an incoming square wave
//
// Measures the rising-edge-to-rising-edge period of sig_in, maps it to symbol k
// where P(k) = 2*UNIT*(k+1) +/- TOL clk cycles, filters single-period glitches,
// and reports lock and loss of signal.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   sig_in     in   asynchronous square-wave input
//   code       out  last accepted symbol
//   code_valid out  one-cycle pulse when code takes a newly accepted value
//   locked     out  accepted code is being confirmed by incoming periods
//   lost       out  no edge seen for TIMEOUT cycles
module frq_decoder #(
    parameter int UNIT   = 4,
    parameter int TOL    = 1,
    parameter int STABLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_in,
    output logic [2:0] code,
    output logic       code_valid,
    output logic       locked,
    output logic       lost
);

    localparam int TIMEOUT = 2 * UNIT * 9;
    localparam int CW      = $clog2(TIMEOUT + 1);
    localparam int MW      = $clog2(STABLE + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [MW-1:0] M_MAX   = MW'(STABLE);

    typedef enum logic {
        S_IDLE,
        S_MEASURE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [2:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_cand, w_cand_nxt;
    logic [MW-1:0] r_m, w_m_nxt, w_m_step;
    logic [2:0]    r_code, w_code_nxt;
    logic          r_code_valid, w_code_valid_nxt;
    logic          r_locked, w_locked_nxt;
    logic          r_lost, w_lost_nxt;
    logic          r_first, w_first_nxt;

    logic          w_edge;
    logic [3:0]    w_hits;
    logic [2:0]    w_k;
    logic          w_valid;

    // r_sync[1:0] is the synchronizer, r_sync[2] the edge-detect history flop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], sig_in};
        end
    end

    assign w_edge = r_sync[1] & ~r_sync[2];

    // cnt holds the period measured so far; saturation keeps classification overflow-free
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_edge) begin
            r_cnt <= CW'(1);
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // TOL < UNIT keeps the windows disjoint, but counting hits keeps an overlap from
    // silently picking the highest k if the parameters are ever misused
    always_comb begin
        w_hits = 4'd0;
        w_k    = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if ((int'(r_cnt) >= 2 * UNIT * (k + 1) - TOL) &&
                (int'(r_cnt) <= 2 * UNIT * (k + 1) + TOL)) begin
                w_hits = w_hits + 4'd1;
                w_k    = 3'(k);
            end
        end
    end

    assign w_valid  = (w_hits == 4'd1);
    assign w_m_step = (w_k == r_cand) ? ((r_m == M_MAX) ? r_m : r_m + MW'(1)) : MW'(1);

    always_comb begin
        w_state_nxt      = r_state;
        w_cand_nxt       = r_cand;
        w_m_nxt          = r_m;
        w_code_nxt       = r_code;
        w_code_valid_nxt = 1'b0;
        w_locked_nxt     = r_locked;
        w_lost_nxt       = r_lost;
        w_first_nxt      = r_first;

        case (r_state)
            S_IDLE: begin
                // first edge after reset or loss only opens a measurement window
                if (w_edge) begin
                    w_state_nxt = S_MEASURE;
                    w_lost_nxt  = 1'b0;
                end
            end
            S_MEASURE: begin
                // an edge coinciding with saturation is still classified (and is invalid)
                if (w_edge) begin
                    w_lost_nxt = 1'b0;
                    if (!w_valid) begin
                        w_m_nxt      = '0;
                        w_locked_nxt = 1'b0;
                    end else begin
                        w_cand_nxt = w_k;
                        w_m_nxt    = w_m_step;
                        if ((w_m_step == M_MAX) && ((w_k != r_code) || !r_locked)) begin
                            w_code_nxt       = w_k;
                            w_locked_nxt     = 1'b1;
                            w_code_valid_nxt = (w_k != r_code) || r_first;
                            w_first_nxt      = 1'b0;
                        end
                    end
                end else if (r_cnt == CNT_MAX) begin
                    w_lost_nxt   = 1'b1;
                    w_locked_nxt = 1'b0;
                    w_m_nxt      = '0;
                    w_first_nxt  = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cand       <= 3'd0;
            r_m          <= '0;
            r_code       <= 3'd0;
            r_code_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_lost       <= 1'b0;
            r_first      <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cand       <= w_cand_nxt;
            r_m          <= w_m_nxt;
            r_code       <= w_code_nxt;
            r_code_valid <= w_code_valid_nxt;
            r_locked     <= w_locked_nxt;
            r_lost       <= w_lost_nxt;
            r_first      <= w_first_nxt;
        end
    end

    assign code       = r_code;
    assign code_valid = r_code_valid;
    assign locked     = r_locked;
    assign lost       = r_lost;

endmodule

// File: tb/tb_frq_decoder.sv
// tb/tb_frq_decoder.sv - directed self-checking bench for frq_decoder
module tb_frq_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sig_in = 1'b0;
    logic [2:0] code;
    logic       code_valid;
    logic       locked;
    logic       lost;

    int n_pass = 0;
    int n_total = 0;
    int cv_count = 0;
    int base;

    frq_decoder #(.UNIT(4), .TOL(1), .STABLE(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .code       (code),
        .code_valid (code_valid),
        .locked     (locked),
        .lost       (lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid === 1'b1) cv_count++;
    end

    // one full period of n cycles starting with a rising transition at a negedge
    task automatic send_period(input int n);
        sig_in = 1'b1;
        repeat (n / 2) @(negedge clk);
        sig_in = 1'b0;
        repeat (n - n / 2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        if (code !== 3'd0) $display("FAIL reset_code: got %0d expected 0", code); else n_pass++;
        n_total++;
        if (code_valid !== 1'b0) $display("FAIL reset_cv: got %b expected 0", code_valid); else n_pass++;
        n_total++;
        if (locked !== 1'b0) $display("FAIL reset_locked: got %b expected 0", locked); else n_pass++;
        n_total++;
        if (lost !== 1'b0) $display("FAIL reset_lost: got %b expected 0", lost); else n_pass++;
        n_total++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_first_lock();
        base = cv_count;
        send_period(24);
        send_period(24);
        // third rising edge: outputs must change exactly 3 negedges after the transition
        sig_in = 1'b1;
        repeat (2) @(negedge clk);
        if (locked !== 1'b0) $display("FAIL lock_early: got %b expected 0", locked); else n_pass++;
        n_total++;
        @(negedge clk);
        if (locked !== 1'b1) $display("FAIL lock_locked: got %b expected 1", locked); else n_pass++;
        n_total++;
        if (code !== 3'd2) $display("FAIL lock_code: got %0d expected 2", code); else n_pass++;
        n_total++;
        if (code_valid !== 1'b1) $display("FAIL lock_cv_high: got %b expected 1", code_valid); else n_pass++;
        n_total++;
        @(negedge clk);
        if (code_valid !== 1'b0) $display("FAIL lock_cv_low: got %b expected 0", code_valid); else n_pass++;
        n_total++;
        repeat (8) @(negedge clk);
        sig_in = 1'b0;
        repeat (12) @(negedge clk);
        send_period(24);
        send_period(24);
        if (cv_count - base !== 1) $display("FAIL lock_pulses: got %0d expected 1", cv_count - base); else n_pass++;
        n_total++;
        if (locked !== 1'b1) $display("FAIL lock_hold: got %b expected 1", locked); else n_pass++;
        n_total++;
    endtask

    task automatic test_switch();
        base = cv_count;
        send_period(56);
        send_period(56);
        if (code !== 3'd2) $display("FAIL switch_hold_code: got %0d expected 2", code); else n_pass++;
        n_total++;
        if (locked !== 1'b1) $display("FAIL switch_hold_locked: got %b expected 1", locked); else n_pass++;
        n_total++;
        if (cv_count - base !== 0) $display("FAIL switch_hold_pulses: got %0d expected 0", cv_count - base); else n_pass++;
        n_total++;
        send_period(56);
        if (code !== 3'd6) $display("FAIL switch_code: got %0d expected 6", code); else n_pass++;
        n_total++;
        if (cv_count - base !== 1) $display("FAIL switch_pulses: got %0d expected 1", cv_count - base); else n_pass++;
        n_total++;
    endtask

    task automatic test_tolerance();
        send_period(24);
        send_period(24);
        if (code !== 3'd6) $display("FAIL tol_keep_code: got %0d expected 6", code); else n_pass++;
        n_total++;
        if (locked !== 1'b1) $display("FAIL tol_keep_locked: got %b expected 1", locked); else n_pass++;
        n_total++;
        send_period(24);
        if (code !== 3'd2) $display("FAIL tol_back_code: got %0d expected 2", code); else n_pass++;
        n_total++;
        base = cv_count;
        send_period(23);
        send_period(25);
        send_period(24);
        send_period(26);
        if (locked !== 1'b1) $display("FAIL tol_edges_locked: got %b expected 1", locked); else n_pass++;
        n_total++;
        if (cv_count - base !== 0) $display("FAIL tol_edges_pulses: got %0d expected 0", cv_count - base); else n_pass++;
        n_total++;
        send_period(24);
        if (locked !== 1'b0) $display("FAIL tol_26_locked: got %b expected 0", locked); else n_pass++;
        n_total++;
        if (code !== 3'd2) $display("FAIL tol_26_code: got %0d expected 2", code); else n_pass++;
        n_total++;
        send_period(24);
        if (locked !== 1'b0) $display("FAIL tol_relock_early: got %b expected 0", locked); else n_pass++;
        n_total++;
        send_period(24);
        if (locked !== 1'b1) $display("FAIL tol_relock: got %b expected 1", locked); else n_pass++;
        n_total++;
        if (code !== 3'd2) $display("FAIL tol_relock_code: got %0d expected 2", code); else n_pass++;
        n_total++;
    endtask

    task automatic test_glitch();
        send_period(10);
        send_period(30);
        if (locked !== 1'b0) $display("FAIL glitch_10_locked: got %b expected 0", locked); else n_pass++;
        n_total++;
        if (code !== 3'd2) $display("FAIL glitch_10_code: got %0d expected 2", code); else n_pass++;
        n_total++;
        send_period(24);
        if (locked !== 1'b0) $display("FAIL glitch_30_locked: got %b expected 0", locked); else n_pass++;
        n_total++;
        if (code !== 3'd2) $display("FAIL glitch_30_code: got %0d expected 2", code); else n_pass++;
        n_total++;
    endtask

    task automatic test_timeout();
        send_period(24);
        send_period(24);
        if (locked !== 1'b1) $display("FAIL to_prelock: got %b expected 1", locked); else n_pass++;
        n_total++;
        sig_in = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (n == 12) sig_in = 1'b0;
            if (n == 74) begin
                if (lost !== 1'b0) $display("FAIL to_lost_early: got %b expected 0", lost); else n_pass++;
                n_total++;
                if (locked !== 1'b1) $display("FAIL to_locked_early: got %b expected 1", locked); else n_pass++;
                n_total++;
            end
            if (n == 75) begin
                if (lost !== 1'b1) $display("FAIL to_lost: got %b expected 1", lost); else n_pass++;
                n_total++;
                if (locked !== 1'b0) $display("FAIL to_locked: got %b expected 0", locked); else n_pass++;
                n_total++;
            end
        end
        sig_in = 1'b1;
        repeat (2) @(negedge clk);
        if (lost !== 1'b1) $display("FAIL to_lost_hold: got %b expected 1", lost); else n_pass++;
        n_total++;
        @(negedge clk);
        if (lost !== 1'b0) $display("FAIL to_lost_clear: got %b expected 0", lost); else n_pass++;
        n_total++;
        repeat (9) @(negedge clk);
        sig_in = 1'b0;
        repeat (12) @(negedge clk);
        base = cv_count;
        send_period(24);
        if (locked !== 1'b0) $display("FAIL to_relock_early: got %b expected 0", locked); else n_pass++;
        n_total++;
        send_period(24);
        if (locked !== 1'b1) $display("FAIL to_relock: got %b expected 1", locked); else n_pass++;
        n_total++;
        if (cv_count - base !== 1) $display("FAIL to_relock_pulses: got %0d expected 1", cv_count - base); else n_pass++;
        n_total++;
    endtask

    task automatic test_reset_mid();
        sig_in = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if (code !== 3'd0) $display("FAIL rmid_code: got %0d expected 0", code); else n_pass++;
        n_total++;
        if (locked !== 1'b0) $display("FAIL rmid_locked: got %b expected 0", locked); else n_pass++;
        n_total++;
        if (lost !== 1'b0) $display("FAIL rmid_lost: got %b expected 0", lost); else n_pass++;
        n_total++;
        if (code_valid !== 1'b0) $display("FAIL rmid_cv: got %b expected 0", code_valid); else n_pass++;
        n_total++;
        base = cv_count;
        repeat (20) @(negedge clk);
        sig_in = 1'b0;
        repeat (20) @(negedge clk);
        if (cv_count - base !== 0) $display("FAIL rmid_start_pulses: got %0d expected 0", cv_count - base); else n_pass++;
        n_total++;
        send_period(24);
        send_period(24);
        send_period(24);
        if (code !== 3'd2) $display("FAIL rmid_relock_code: got %0d expected 2", code); else n_pass++;
        n_total++;
        if (cv_count - base !== 1) $display("FAIL rmid_relock_pulses: got %0d expected 1", cv_count - base); else n_pass++;
        n_total++;
    endtask

    initial begin
        test_reset();
        test_first_lock();
        test_switch();
        test_tolerance();
        test_glitch();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
